// File: rtl/bram_tdp_readback_checker.sv
// bram_tdp_readback_checker
//   Scoreboard for a gold/gate true-dual-port BRAM pair on one clock. Tracks
//   which addresses hold defined data, qualifies each port's read and
//   compares gold vs gate read data one cycle later. It counts checks and
//   mismatches and latches the port and address of the first mismatch.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   clear                 synchronous clear of all checker state
//   a_a, we_a             port A address / write enable
//   a_b, we_b             port B address / write enable
//   gold_rd_a, gate_rd_a  port A read data from gold and gate memories
//   gold_rd_b, gate_rd_b  port B read data from gold and gate memories
//   err                   sticky flag: at least one mismatch seen
//   err_port, err_addr    port (0 = A, 1 = B) and address of the first mismatch
//   mismatch_cnt          saturating count of mismatching compares
//   check_cnt             saturating count of compares performed
module bram_tdp_readback_checker #(
  parameter int ABITS = 10,
  parameter int DBITS = 36,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [ABITS-1:0] a_a,
  input  logic             we_a,
  input  logic [ABITS-1:0] a_b,
  input  logic             we_b,
  input  logic [DBITS-1:0] gold_rd_a,
  input  logic [DBITS-1:0] gate_rd_a,
  input  logic [DBITS-1:0] gold_rd_b,
  input  logic [DBITS-1:0] gate_rd_b,
  output logic             err,
  output logic             err_port,
  output logic [ABITS-1:0] err_addr,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] check_cnt
);

  localparam int DEPTH = 2 ** ABITS;

  logic [DEPTH-1:0] written;
  logic             pend_a;
  logic             pend_b;
  logic [ABITS-1:0] pend_addr_a;
  logic [ABITS-1:0] pend_addr_b;

  logic             same_addr;
  logic             qual_a;
  logic             qual_b;
  logic             mis_a;
  logic             mis_b;
  logic [1:0]       n_chk;
  logic [1:0]       n_mis;

  // Adds 0..2 with clamping; the extra sum bit catches any overflow.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    same_addr = (a_a == a_b);
    // A read is only trusted when the location was defined before this cycle
    // and the other port is not writing it right now; an own-port write is
    // allowed so read-during-write behaviour is compared too.
    qual_a    = written[a_a] && !(we_b && same_addr);
    qual_b    = written[a_b] && !(we_a && same_addr);
    // Case inequality so X/Z on either side counts as a mismatch.
    mis_a     = pend_a && (gold_rd_a !== gate_rd_a);
    mis_b     = pend_b && (gold_rd_b !== gate_rd_b);
    n_chk     = {1'b0, pend_a} + {1'b0, pend_b};
    n_mis     = {1'b0, mis_a} + {1'b0, mis_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written      <= '0;
      pend_a       <= 1'b0;
      pend_b       <= 1'b0;
      pend_addr_a  <= '0;
      pend_addr_b  <= '0;
      err          <= 1'b0;
      err_port     <= 1'b0;
      err_addr     <= '0;
      mismatch_cnt <= '0;
      check_cnt    <= '0;
    end else if (clear) begin
      written      <= '0;
      pend_a       <= 1'b0;
      pend_b       <= 1'b0;
      pend_addr_a  <= '0;
      pend_addr_b  <= '0;
      err          <= 1'b0;
      err_port     <= 1'b0;
      err_addr     <= '0;
      mismatch_cnt <= '0;
      check_cnt    <= '0;
    end else begin
      pend_a      <= qual_a;
      pend_b      <= qual_b;
      pend_addr_a <= a_a;
      pend_addr_b <= a_b;

      // Later assignment wins: a same-address dual write leaves the
      // location undefined.
      if (we_a) written[a_a] <= 1'b1;
      if (we_b) written[a_b] <= 1'b1;
      if (we_a && we_b && same_addr) written[a_a] <= 1'b0;

      check_cnt    <= sat_add(check_cnt, n_chk);
      mismatch_cnt <= sat_add(mismatch_cnt, n_mis);

      // Port A takes precedence when both ports mismatch together.
      if (!err && (mis_a || mis_b)) begin
        err      <= 1'b1;
        err_port <= !mis_a;
        err_addr <= mis_a ? pend_addr_a : pend_addr_b;
      end
    end
  end

endmodule

// File: tb/tb_bram_tdp_readback_checker.sv
module tb_bram_tdp_readback_checker;

  localparam int AW   = 4;
  localparam int DW   = 36;
  localparam int CW   = 6;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          clear;
  logic [AW-1:0] a_a;
  logic          we_a;
  logic [AW-1:0] a_b;
  logic          we_b;
  logic [DW-1:0] gold_rd_a;
  logic [DW-1:0] gate_rd_a;
  logic [DW-1:0] gold_rd_b;
  logic [DW-1:0] gate_rd_b;
  logic          err;
  logic          err_port;
  logic [AW-1:0] err_addr;
  logic [CW-1:0] mismatch_cnt;
  logic [CW-1:0] check_cnt;

  bram_tdp_readback_checker #(.ABITS(AW), .DBITS(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .a_a          (a_a),
    .we_a         (we_a),
    .a_b          (a_b),
    .we_b         (we_b),
    .gold_rd_a    (gold_rd_a),
    .gate_rd_a    (gate_rd_a),
    .gold_rd_b    (gold_rd_b),
    .gate_rd_b    (gate_rd_b),
    .err          (err),
    .err_port     (err_port),
    .err_addr     (err_addr),
    .mismatch_cnt (mismatch_cnt),
    .check_cnt    (check_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: the set of defined addresses, the reads still awaiting
  // their data, and the visible result state.
  typedef struct { bit port; int addr; } rd_t;
  typedef struct { bit err; bit eport; int eaddr; int mcnt; int ccnt; } exp_t;

  bit   wr_m[1 << AW];
  rd_t  outst[$];
  exp_t expq[$];
  int   m_ccnt, m_mcnt, m_addr;
  bit   m_err, m_port;

  function automatic int min_i(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic model_clear();
    foreach (wr_m[i]) wr_m[i] = 1'b0;
    outst.delete();
    m_ccnt = 0; m_mcnt = 0; m_err = 0; m_port = 0; m_addr = 0;
  endtask

  // One bench cycle: drive inputs after the sampling edge, advance the model
  // across the coming rising edge and queue the expected outputs.
  task automatic step(input bit r, input bit c,
                      input bit wa, input logic [AW-1:0] aa,
                      input bit wb, input logic [AW-1:0] ab,
                      input logic [DW-1:0] ga, input logic [DW-1:0] gta,
                      input logic [DW-1:0] gb, input logic [DW-1:0] gtb);
    int  n, nm;
    bit  mism;
    exp_t e;
    @(negedge clk); #1;
    rst = r; clear = c; we_a = wa; a_a = aa; we_b = wb; a_b = ab;
    gold_rd_a = ga; gate_rd_a = gta; gold_rd_b = gb; gate_rd_b = gtb;
    if (r) begin
      #1;
      chk("async_rst_err", err, 0);
      chk("async_rst_check_cnt", check_cnt, 0);
      chk("async_rst_mismatch_cnt", mismatch_cnt, 0);
    end
    if (r || c) begin
      model_clear();
    end else begin
      n = 0; nm = 0;
      foreach (outst[i]) begin
        n++;
        mism = outst[i].port ? (gb !== gtb) : (ga !== gta);
        if (mism) begin
          nm++;
          if (!m_err) begin
            m_err = 1; m_port = outst[i].port; m_addr = outst[i].addr;
          end
        end
      end
      m_ccnt = min_i(m_ccnt + n, MAXC);
      m_mcnt = min_i(m_mcnt + nm, MAXC);
      outst.delete();
      if (wr_m[aa] && !(wb && ab == aa)) outst.push_back('{1'b0, int'(aa)});
      if (wr_m[ab] && !(wa && aa == ab)) outst.push_back('{1'b1, int'(ab)});
      if (wa) wr_m[aa] = 1'b1;
      if (wb) wr_m[ab] = 1'b1;
      if (wa && wb && aa == ab) wr_m[aa] = 1'b0;
    end
    e.err = m_err; e.eport = m_port; e.eaddr = m_addr;
    e.mcnt = m_mcnt; e.ccnt = m_ccnt;
    expq.push_back(e);
  endtask

  task automatic cyc(input bit wa, input logic [AW-1:0] aa,
                     input bit wb, input logic [AW-1:0] ab,
                     input logic [DW-1:0] ga, input logic [DW-1:0] gta,
                     input logic [DW-1:0] gb, input logic [DW-1:0] gtb);
    step(1'b0, 1'b0, wa, aa, wb, ab, ga, gta, gb, gtb);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Monitor: pops one expectation per cycle once outputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("err", err, e.err);
        chk("err_port", err_port, e.eport);
        chk("err_addr", err_addr, e.eaddr);
        chk("mismatch_cnt", mismatch_cnt, e.mcnt);
        chk("check_cnt", check_cnt, e.ccnt);
      end
    end
  end

  localparam logic [DW-1:0] D   = 36'h123456789;
  localparam logic [DW-1:0] Z0  = 36'h0;
  localparam logic [DW-1:0] P1  = 36'hAAAAAAAAA;
  localparam logic [DW-1:0] P2  = 36'h555555555;

  initial begin
    logic [DW-1:0] ga, gta, gb, gtb;
    rst = 1'b1; clear = 1'b0; we_a = 1'b0; we_b = 1'b0; a_a = '0; a_b = '0;
    gold_rd_a = '0; gate_rd_a = '0; gold_rd_b = '0; gate_rd_b = '0;
    model_clear();

    step(1, 0, 0, 15, 0, 15, Z0, Z0, Z0, Z0);
    step(1, 0, 0, 15, 0, 15, Z0, Z0, Z0, Z0);

    // Write addr 5 on A, read it back on A two cycles later, data agrees.
    cyc(1, 5, 0, 15, Z0, Z0, Z0, Z0);
    cyc(0, 15, 0, 15, Z0, Z0, Z0, Z0);
    cyc(0, 5, 0, 15, Z0, Z0, Z0, Z0);
    cyc(0, 15, 0, 15, D, D, Z0, Z0);

    // Read addr 5 on B with the gate output stuck at zero, then a clean read.
    cyc(0, 15, 0, 5, Z0, Z0, Z0, Z0);
    cyc(0, 15, 0, 15, Z0, Z0, D, Z0);
    cyc(0, 5, 0, 15, Z0, Z0, Z0, Z0);
    cyc(0, 15, 0, 15, D, D, Z0, Z0);

    // Addr 7: unwritten read, read during other-port write, then a real read.
    cyc(0, 7, 0, 15, Z0, Z0, Z0, Z0);
    cyc(0, 15, 0, 15, P1, P2, Z0, Z0);
    cyc(0, 7, 1, 7, Z0, Z0, Z0, Z0);
    cyc(0, 15, 0, 15, P1, P2, Z0, Z0);
    cyc(0, 7, 0, 15, Z0, Z0, Z0, Z0);
    cyc(0, 15, 0, 15, D, D, Z0, Z0);

    // Same-address dual write leaves addr 3 undefined.
    cyc(1, 3, 1, 3, Z0, Z0, Z0, Z0);
    cyc(0, 3, 0, 3, Z0, Z0, Z0, Z0);
    cyc(0, 15, 0, 15, P1, P2, P2, P1);

    // Both ports mismatching every cycle until both counters clamp.
    step(0, 1, 0, 15, 0, 15, Z0, Z0, Z0, Z0);
    cyc(1, 1, 1, 2, Z0, Z0, Z0, Z0);
    for (int i = 0; i < 34; i++) cyc(0, 1, 0, 2, P1, P2, P2, P1);
    cyc(0, 15, 0, 15, P1, P2, P2, P1);

    // Async reset with a compare pending; old addresses must not requalify.
    cyc(0, 1, 0, 2, Z0, Z0, Z0, Z0);
    step(1, 0, 0, 1, 0, 2, P1, P2, P2, P1);
    cyc(0, 1, 0, 2, P1, P2, P2, P1);
    cyc(0, 15, 0, 15, P1, P2, P2, P1);

    // Same sequence with a synchronous clear.
    cyc(1, 1, 1, 2, Z0, Z0, Z0, Z0);
    cyc(0, 1, 0, 2, Z0, Z0, Z0, Z0);
    step(0, 1, 0, 1, 0, 2, P1, P2, P2, P1);
    cyc(0, 1, 0, 2, P1, P2, P2, P1);
    cyc(0, 15, 0, 15, P1, P2, P2, P1);

    // Random traffic over a small address space to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      bit r, c;
      r = ($urandom_range(199, 0) == 0);
      c = ($urandom_range(149, 0) == 0);
      ga = rnd_data(); gb = rnd_data();
      gta = ($urandom_range(9, 0) < 2) ? (ga ^ (36'h1 << $urandom_range(DW - 1, 0))) : ga;
      gtb = ($urandom_range(9, 0) < 2) ? (gb ^ (36'h1 << $urandom_range(DW - 1, 0))) : gb;
      step(r, c, ($urandom_range(9, 0) < 3), AW'($urandom_range(15, 0)),
           ($urandom_range(9, 0) < 3), AW'($urandom_range(15, 0)),
           ga, gta, gb, gtb);
    end

    cyc(0, 15, 0, 15, Z0, Z0, Z0, Z0);
    repeat (3) @(negedge clk);
    #1;
    chk("queue_drain", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
